// File: rtl/enc8b10b_pkg.sv
// ----------------------------------------------------------------------------
// enc8b10b_pkg
// Shared constants and types for the 8b/10b serial datapath.
//   CW_W        : codeword width (10 bits, {a,b,c,d,e,i,f,g,h,j})
//   K28_5_RDN   : K28.5 comma sent while running disparity is negative
//   K28_5_RDP   : K28.5 comma sent while running disparity is positive
//   ser_state_t : serializer FSM states (EMPTY = line parked, SHIFT = sending)
// ----------------------------------------------------------------------------
package enc8b10b_pkg;

    localparam int CW_W = 10;

    localparam logic [CW_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [CW_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/serializer_10b_rd_tracker.sv
// ----------------------------------------------------------------------------
// rd_tracker
// Running-disparity bookkeeping for the serializer. On every word load it
// counts the ones in the loaded codeword, updates RD and (optionally) flags
// disparity violations.
//
// Optional feature macro: SER_DISP_CHECK_EN
//   defined   : disp_err is a sticky violation flag, cleared by err_clr
//   undefined : disp_err is tied 0 and err_clr is ignored
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   load_en   in   a codeword is being loaded onto the line this edge
//   word      in   [9:0] codeword being loaded
//   err_clr   in   clears disp_err (set on the same edge wins)
//   rd        out  current running disparity (0 = negative, 1 = positive)
//   disp_err  out  sticky disparity violation flag
// ----------------------------------------------------------------------------
module rd_tracker
    import enc8b10b_pkg::*;
#(
    parameter bit RD_INIT = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [CW_W-1:0] word,
    input  logic            err_clr,
    output logic            rd,
    output logic            disp_err
);

    logic [3:0] ones;
    logic       rd_reg;

    // Population count of the codeword being loaded.
    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < CW_W; i++) begin
            ones = ones + {3'b000, word[i]};
        end
    end

    // Balanced (5 ones) and illegal counts leave RD alone; 6 ones drives it
    // positive, 4 ones drives it negative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg <= RD_INIT;
        end else if (load_en) begin
            if (ones == 4'd6) begin
                rd_reg <= 1'b1;
            end else if (ones == 4'd4) begin
                rd_reg <= 1'b0;
            end
        end
    end

    assign rd = rd_reg;

`ifdef SER_DISP_CHECK_EN
    logic disp_err_reg;
    logic violation;

    // A violation is an unbalanced word pushing RD further the way it already
    // leans, or any ones count that no valid codeword can have.
    always_comb begin
        violation = 1'b0;
        if ((ones == 4'd6) && rd_reg) begin
            violation = 1'b1;
        end else if ((ones == 4'd4) && !rd_reg) begin
            violation = 1'b1;
        end else if ((ones < 4'd4) || (ones > 4'd6)) begin
            violation = 1'b1;
        end
    end

    // Set has priority over clear so a violation on the clearing edge is
    // never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_err_reg <= 1'b0;
        end else if (load_en && violation) begin
            disp_err_reg <= 1'b1;
        end else if (err_clr) begin
            disp_err_reg <= 1'b0;
        end
    end

    assign disp_err = disp_err_reg;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign disp_err       = 1'b0;
`endif

endmodule

// File: rtl/serializer_10b.sv
// ----------------------------------------------------------------------------
// serializer_10b
// Takes 10-bit codewords from the 8b/10b encoder over a valid/ready handshake
// into a 1-deep hold register and shifts them out one bit per clock, bit 'a'
// (d_in[9]) first. Words go out back to back with no gap bits. When the hold
// register is empty at a word boundary the line is filled with a K28.5 comma
// of the polarity matching the current running disparity (IDLE_INSERT=1), or
// parked at 0 in the EMPTY state (IDLE_INSERT=0).
//
// Optional feature macro: SER_DISP_CHECK_EN (enables the disparity error
// flag inside rd_tracker; without it disp_err is 0 and err_clr is ignored).
//
// Parameters:
//   IDLE_INSERT  1: send K28.5 when starved, 0: park the line at 0
//   RD_INIT      running disparity after reset (0 = negative, 1 = positive)
//
// Ports:
//   clk          in   clock, one serial bit per rising edge
//   rst_n        in   asynchronous active-low reset
//   d_in         in   [9:0] codeword {a,b,c,d,e,i,f,g,h,j}
//   d_valid      in   d_in is valid
//   d_ready      out  hold register empty (registered)
//   err_clr      in   clears disp_err
//   ser_out      out  serial bit
//   word_start   out  high while ser_out carries bit 'a' of any word
//   idle_active  out  high for all 10 bits of an inserted K28.5
//   rd_out       out  running disparity, updated when a word is loaded
//   disp_err     out  sticky disparity violation flag
// ----------------------------------------------------------------------------
module serializer_10b
    import enc8b10b_pkg::*;
#(
    parameter bit IDLE_INSERT = 1'b1,
    parameter bit RD_INIT     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW_W-1:0] d_in,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic            err_clr,
    output logic            ser_out,
    output logic            word_start,
    output logic            idle_active,
    output logic            rd_out,
    output logic            disp_err
);

    ser_state_t      state_reg;
    logic [3:0]      bcnt_reg;
    logic [CW_W-2:0] shift_reg;      // remaining bits b..j of the word on the line
    logic [CW_W-1:0] hold_reg;
    logic            hold_full_reg;
    logic            d_ready_reg;
    logic            ser_out_reg;
    logic            word_start_reg;
    logic            idle_active_reg;

    logic            transfer;
    logic            load_evt;
    logic            load_valid;
    logic [CW_W-1:0] comma_word;
    logic [CW_W-1:0] load_word;
    logic            hold_full_next;
    logic [CW_W-1:0] hold_next;
    logic            rd_cur;

    assign transfer   = d_valid & d_ready_reg;

    // A word boundary: either the line is parked, or the last bit (j) of the
    // current word is on the line.
    assign load_evt   = (state_reg == EMPTY) || (bcnt_reg == 4'd9);

    // The comma polarity follows the disparity before the comma is sent.
    assign comma_word = rd_cur ? K28_5_RDP : K28_5_RDN;
    assign load_word  = hold_full_reg ? hold_reg : comma_word;

    // Something actually goes on the line at this boundary.
    assign load_valid = load_evt && (hold_full_reg || IDLE_INSERT);

    // A new transfer on the same edge as the hold word leaves for the line
    // refills the hold register, so it stays full.
    always_comb begin
        hold_full_next = hold_full_reg;
        hold_next      = hold_reg;
        if (transfer) begin
            hold_full_next = 1'b1;
            hold_next      = d_in;
        end else if (load_evt && hold_full_reg) begin
            hold_full_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= EMPTY;
            bcnt_reg        <= 4'd0;
            shift_reg       <= '0;
            hold_reg        <= '0;
            hold_full_reg   <= 1'b0;
            d_ready_reg     <= 1'b0;
            ser_out_reg     <= 1'b0;
            word_start_reg  <= 1'b0;
            idle_active_reg <= 1'b0;
        end else begin
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            d_ready_reg   <= ~hold_full_next;

            if (load_valid) begin
                state_reg       <= SHIFT;
                bcnt_reg        <= 4'd0;
                shift_reg       <= load_word[CW_W-2:0];
                ser_out_reg     <= load_word[CW_W-1];
                word_start_reg  <= 1'b1;
                idle_active_reg <= ~hold_full_reg;
            end else if (load_evt) begin
                // Starved with idle insertion disabled: park the line low.
                state_reg       <= EMPTY;
                bcnt_reg        <= 4'd0;
                shift_reg       <= '0;
                ser_out_reg     <= 1'b0;
                word_start_reg  <= 1'b0;
                idle_active_reg <= 1'b0;
            end else begin
                state_reg      <= SHIFT;
                bcnt_reg       <= bcnt_reg + 4'd1;
                shift_reg      <= {shift_reg[CW_W-3:0], 1'b0};
                ser_out_reg    <= shift_reg[CW_W-2];
                word_start_reg <= 1'b0;
            end
        end
    end

    rd_tracker #(
        .RD_INIT (RD_INIT)
    ) u_rd_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_valid),
        .word     (load_word),
        .err_clr  (err_clr),
        .rd       (rd_cur),
        .disp_err (disp_err)
    );

    assign d_ready     = d_ready_reg;
    assign ser_out     = ser_out_reg;
    assign word_start  = word_start_reg;
    assign idle_active = idle_active_reg;
    assign rd_out      = rd_cur;

endmodule

// File: tb/tb_serializer_10b.sv
// ----------------------------------------------------------------------------
// tb_serializer_10b
// Directed bench for serializer_10b. Instance u_dut_a runs with idle
// insertion, u_dut_b without. Expected bit streams, disparity values and
// handshake timing are hand-derived constants.
// ----------------------------------------------------------------------------
module tb_serializer_10b;

`ifdef SER_DISP_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    localparam logic [9:0] RDN  = 10'b0011111010;
    localparam logic [9:0] RDP  = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] W_A  = 10'b1001110100;
    localparam logic [9:0] W_B  = 10'b0011111010;
    localparam logic [9:0] W_E4 = 10'b1100000101;
    localparam logic [9:0] W_Z  = 10'b0000000000;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [9:0] d_in_a;
    logic       d_valid_a;
    logic       err_clr_a;
    logic       d_ready_a, ser_out_a, word_start_a, idle_active_a, rd_out_a, disp_err_a;

    logic [9:0] d_in_b;
    logic       d_valid_b;
    logic       err_clr_b;
    logic       d_ready_b, ser_out_b, word_start_b, idle_active_b, rd_out_b, disp_err_b;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    serializer_10b #(.IDLE_INSERT(1'b1), .RD_INIT(1'b0)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in_a),
        .d_valid     (d_valid_a),
        .d_ready     (d_ready_a),
        .err_clr     (err_clr_a),
        .ser_out     (ser_out_a),
        .word_start  (word_start_a),
        .idle_active (idle_active_a),
        .rd_out      (rd_out_a),
        .disp_err    (disp_err_a)
    );

    serializer_10b #(.IDLE_INSERT(1'b0), .RD_INIT(1'b0)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in_b),
        .d_valid     (d_valid_b),
        .d_ready     (d_ready_b),
        .err_clr     (err_clr_b),
        .ser_out     (ser_out_b),
        .word_start  (word_start_b),
        .idle_active (idle_active_b),
        .rd_out      (rd_out_b),
        .disp_err    (disp_err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: retire the head of the push queue if it was accepted on this
    // edge, then present the next queued word. Samples are taken 1 time unit
    // after the rising edge.
    task automatic step();
        logic xfer;
        xfer = d_valid_a && d_ready_a;
        @(posedge clk);
        #1;
        if (xfer) void'(q.pop_front());
        if (q.size() > 0) begin
            d_valid_a = 1'b1;
            d_in_a    = q[0];
        end else begin
            d_valid_a = 1'b0;
            d_in_a    = '0;
        end
    endtask

    task automatic push(input logic [9:0] w);
        q.push_back(w);
        if (q.size() == 1) begin
            d_valid_a = 1'b1;
            d_in_a    = w;
        end
    endtask

    // Observe one full word on instance A, starting with its load edge.
    task automatic expect_word(input string tag, input logic [9:0] exp_w,
                               input logic exp_idle, input logic exp_rd,
                               input int exp_low);
        logic [9:0] ser_v, ws_v, idle_v;
        int         low;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            ser_v[9-i]  = ser_out_a;
            ws_v[9-i]   = word_start_a;
            idle_v[9-i] = idle_active_a;
            if (!d_ready_a) low++;
        end
        $display("txn %s: ser=%b ws=%b idle=%b rd=%b ready_low=%0d",
                 tag, ser_v, ws_v, idle_v, rd_out_a, low);
        check({tag, ".bits"}, {22'd0, ser_v}, {22'd0, exp_w});
        check({tag, ".word_start"}, {22'd0, ws_v}, 32'h200);
        check({tag, ".idle"}, {22'd0, idle_v}, exp_idle ? 32'h3ff : 32'h0);
        check({tag, ".rd"}, {31'd0, rd_out_a}, {31'd0, exp_rd});
        check({tag, ".ready_low"}, low, exp_low);
    endtask

    initial begin
        logic [4:0] part;
        logic [9:0] ser_v, ws_v, idle_v;
        logic [2:0] park_v;
        logic       rdy, got;

        rst_n     = 1'b1;
        d_in_a    = '0;
        d_valid_a = 1'b0;
        err_clr_a = 1'b0;
        d_in_b    = '0;
        d_valid_b = 1'b0;
        err_clr_b = 1'b0;
        #2 rst_n  = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst.ser_out",     {31'd0, ser_out_a},     0);
        check("rst.word_start",  {31'd0, word_start_a},  0);
        check("rst.idle",        {31'd0, idle_active_a}, 0);
        check("rst.d_ready",     {31'd0, d_ready_a},     0);
        check("rst.rd",          {31'd0, rd_out_a},      0);
        check("rst.disp_err",    {31'd0, disp_err_a},    0);
        check("rst.b_ser_out",   {31'd0, ser_out_b},     0);
        check("rst.b_d_ready",   {31'd0, d_ready_b},     0);
        rst_n = 1'b1;

        // Idle commas, alternating polarity, back to back
        expect_word("idle1", RDN, 1'b1, 1'b1, 0);
        expect_word("idle2", RDP, 1'b1, 1'b0, 0);
        expect_word("idle3", RDN, 1'b1, 1'b1, 0);

        // Single D.21.5 pushed at a word boundary: held during the next comma
        push(D215);
        expect_word("idle4", RDP, 1'b1, 1'b0, 10);
        expect_word("d21_5", D215, 1'b0, 1'b0, 0);
        expect_word("idle5", RDN, 1'b1, 1'b1, 0);

        // Back-to-back words with valid held
        push(W_A);
        push(W_B);
        expect_word("idle6", RDP, 1'b1, 1'b0, 10);
        expect_word("b2b_1", W_A, 1'b0, 1'b0, 9);
        expect_word("b2b_2", W_B, 1'b0, 1'b1, 0);
        check("b2b.disp_err", {31'd0, disp_err_a}, 0);

        // Disparity errors: 4 ones while negative, then an all-zero word
        push(W_E4);
        expect_word("idle7", RDP, 1'b1, 1'b0, 10);
        expect_word("err4", W_E4, 1'b0, 1'b0, 0);
        check("err4.disp_err", {31'd0, disp_err_a}, {31'd0, CHK});
        push(W_Z);
        expect_word("idle8", RDN, 1'b1, 1'b1, 10);
        expect_word("err0", W_Z, 1'b0, 1'b1, 0);
        check("err0.disp_err", {31'd0, disp_err_a}, {31'd0, CHK});
        err_clr_a = 1'b1;
        expect_word("idle9", RDP, 1'b1, 1'b0, 0);
        err_clr_a = 1'b0;
        check("clr.disp_err", {31'd0, disp_err_a}, 0);

        // Reset in the middle of a comma (bit counter at 4)
        for (int i = 0; i < 5; i++) begin
            step();
            part[4-i] = ser_out_a;
        end
        check("mid.bits",  {27'd0, part}, 32'h07);
        check("mid.rd",    {31'd0, rd_out_a}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst.ser_out",    {31'd0, ser_out_a},     0);
        check("mid_rst.d_ready",    {31'd0, d_ready_a},     0);
        check("mid_rst.word_start", {31'd0, word_start_a},  0);
        check("mid_rst.idle",       {31'd0, idle_active_a}, 0);
        check("mid_rst.rd",         {31'd0, rd_out_a},      0);
        step();
        rst_n = 1'b1;
        expect_word("restart", RDN, 1'b1, 1'b1, 0);

        // Instance B: no idle insertion
        d_valid_b = 1'b1;
        d_in_b    = D215;
        got       = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            rdy = d_ready_b;
            step();
            if (rdy) got = 1'b1;
        end
        check("b.xfer", {31'd0, got}, 1);
        d_valid_b = 1'b0;
        d_in_b    = '0;
        check("b.xfer_ser",  {31'd0, ser_out_b},    0);
        check("b.xfer_ws",   {31'd0, word_start_b}, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            ser_v[9-i]  = ser_out_b;
            ws_v[9-i]   = word_start_b;
            idle_v[9-i] = idle_active_b;
        end
        $display("txn b_word: ser=%b ws=%b idle=%b rd=%b", ser_v, ws_v, idle_v, rd_out_b);
        check("b.bits",       {22'd0, ser_v},  {22'd0, D215});
        check("b.word_start", {22'd0, ws_v},   32'h200);
        check("b.idle",       {22'd0, idle_v}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            park_v[i] = ser_out_b | word_start_b;
        end
        check("b.parked", {29'd0, park_v}, 0);

        // Latency: accepted in EMPTY, bit a on the line one edge later
        d_valid_b = 1'b1;
        d_in_b    = W_A;
        step();
        d_valid_b = 1'b0;
        d_in_b    = '0;
        check("b.lat_ws0",   {31'd0, word_start_b}, 0);
        check("b.lat_ready", {31'd0, d_ready_b},    0);
        step();
        $display("txn b_lat: ws=%b ser=%b", word_start_b, ser_out_b);
        check("b.lat_ws1",   {31'd0, word_start_b}, 1);
        check("b.lat_bit_a", {31'd0, ser_out_b},    1);
        check("b.rd",        {31'd0, rd_out_b},     0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_10b.md
Name: serializer_10b

Overview:
- Downstream neighbour of the 8b/10b encoder. Accepts one 10-bit codeword per valid/ready transfer and shifts it out one bit per clock, bit 'a' first.
- Tracks running disparity (RD) of the transmitted stream.
- When no data is ready at a word boundary, fills the line with K28.5 idle commas of the correct polarity.
- Sits between the registered encoder output and the PHY/pad serial line.

Parameters:
- IDLE_INSERT, 1: 1 sends K28.5 when starved; 0 parks the line at 0 (state EMPTY).
- RD_INIT, 0: RD value after reset (0 = negative, 1 = positive).

Ports:
- CLK  in  1  clock; one serial bit per rising edge.
- RST_N  in  1  asynchronous active-low reset.
- D_IN  in  10  codeword {a,b,c,d,e,i,f,g,h,j}; D_IN[9]=a is transmitted first.
- D_VALID  in  1  D_IN is valid.
- D_READY  out  1  holding register is empty; registered.
- ERR_CLR  in  1  clears DISP_ERR.
- SER_OUT  out  1  serial bit.
- WORD_START  out  1  high while SER_OUT carries bit 'a' of any word.
- IDLE_ACTIVE  out  1  high for all 10 bits of an inserted K28.5.
- RD_OUT  out  1  current RD, updated when a word is loaded.
- DISP_ERR  out  1  sticky disparity violation flag.

Behaviour:
- Reset values: SER_OUT=0, WORD_START=0, IDLE_ACTIVE=0, D_READY=0, RD_OUT=RD_INIT, DISP_ERR=0; state EMPTY, hold register empty.
- First edge after reset release: D_READY goes to 1.
- Handshake:
  - A transfer occurs on an edge where D_VALID & D_READY; the word enters the 1-deep hold register.
  - D_READY = ~hold_full, registered.
  - D_VALID must not drop and D_IN must stay stable until the transfer occurs.
- FSM states: EMPTY and SHIFT; bit counter BCNT runs 0..9.
- Load event, taken in EMPTY on any edge, or in SHIFT on the edge where BCNT==9:
  - Hold full: load the hold word, clear hold; D_READY=1 next cycle.
  - Hold empty and IDLE_INSERT=1: load K28.5, choosing 0011111010 if RD is negative, 1100000101 if RD is positive; IDLE_ACTIVE=1 for that word.
  - Hold empty and IDLE_INSERT=0: go to EMPTY; SER_OUT=0.
  - A load sets BCNT=0, WORD_START=1 and SER_OUT=word[9].
- SHIFT: each edge presents the next lower bit; BCNT increments.
- Throughput: the line carries back-to-back words with no gap bits.
- Simultaneous hold-load and new transfer on the same edge: the hold register takes the new word and stays full.
- Latency: a word accepted while in EMPTY with the hold register empty appears on SER_OUT (bit a) 1 edge after acceptance.
- RD rule, applied at load from the ones count of the loaded word:
  - 5 ones: RD unchanged.
  - 6 ones: RD becomes positive.
  - 4 ones: RD becomes negative.
  - Any other count: RD unchanged.
- Error rule: DISP_ERR sets on a load with 6 ones while RD is positive, 4 ones while RD is negative, or a ones count outside {4,5,6}. ERR_CLR clears it; a set on the same edge wins over the clear.
- Reset mid-word: the word is abandoned immediately and all outputs take their reset values.

Optional Feature:
- SER_DISP_CHECK_EN defined: the error rule is implemented as above.
- Undefined: DISP_ERR is tied 0 and ERR_CLR is ignored. RD tracking and idle polarity selection are unchanged.

Decomposition:
- Package enc8b10b_pkg holds:
  - K28_5_RDN = 10'b0011111010 and K28_5_RDP = 10'b1100000101.
  - CW_W = 10.
  - ser_state_t enum {EMPTY, SHIFT}.
- One sub-module, rd_tracker: popcount of 10 bits, RD register, and error detection (gated by SER_DISP_CHECK_EN).

Test Plan:
- Reset, IDLE_INSERT=1, no D_VALID, RD_INIT=0:
  - SER_OUT sequence 0011111010, 1100000101, 0011111010, … with no gaps.
  - IDLE_ACTIVE=1 throughout; WORD_START every 10th cycle; RD_OUT toggles 1,0,1 at each load.
- Single word 1010101010 (D.21.5) pushed during idle:
  - Sent after the current comma finishes, bit pattern 1,0,1,0,…
  - RD unchanged; IDLE_ACTIVE=0 for that word; D_READY returns 1 at that load.
- Back-to-back words 1001110100 and 0011111010 with D_VALID held:
  - 20 contiguous bits out.
  - D_READY low for 9 cycles per word; RD_OUT goes positive at the second load.
- With RD negative, push 1100000101: DISP_ERR=1 and RD goes negative. Then push 0000000000: DISP_ERR stays 1. Then pulse ERR_CLR: DISP_ERR=0.
- IDLE_INSERT=0, one word 1010101010 then starve:
  - 10 bits out, then SER_OUT=0 in EMPTY.
  - Next word starts 1 edge after its transfer.
- Assert RST_N low at BCNT=4: SER_OUT=0 and D_READY=0 immediately; after release, the word restarts cleanly with an RD_INIT-polarity comma.
